// File: rtl/fetch_unit_if.sv
// Icache request/response and instruction-queue drain signals of the fetch stage.
// master = fetch_unit side, slave = icache / decoder side.
interface fetch_unit_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_inst;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_predict;
  logic        out_ready;
  logic        queue_full;

  modport master (
    output icache_req, icache_addr, out_valid, out_inst, out_pc, out_predict, queue_full,
    input  icache_valid, icache_inst, out_ready
  );

  modport slave (
    input  icache_req, icache_addr, out_valid, out_inst, out_pc, out_predict, queue_full,
    output icache_valid, icache_inst, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch beside the BTB: one outstanding icache request, predecode, instruction queue.
// Optional macro FETCH_STATS_EN adds stat_fetched / stat_stall counters.
module fetch_unit #(
  parameter int QUEUE_SIZE   = 16,
  parameter int QUEUE_ADDR_W = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic [31:0]  pc_in,
  input  logic         predict_in,
  input  logic         stop_fetching,
  input  logic         roll_back,
  output logic         fetch_new_instruction,
  output logic [2:0]   op_type,
  output logic [5:0]   op_in,
  output logic [31:0]  imm,
  fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]  stat_fetched,
  output logic [31:0]  stat_stall
`endif
);

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_JAL  = 3'd1;
  localparam logic [2:0] TYPE_JALR = 3'd2;
  localparam logic [2:0] TYPE_B    = 3'd3;

  localparam logic [5:0] OP_NONE = 6'd0;
  localparam logic [5:0] OP_JAL  = 6'd1;
  localparam logic [5:0] OP_JALR = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd3;
  localparam logic [5:0] OP_BNE  = 6'd4;
  localparam logic [5:0] OP_BLT  = 6'd5;
  localparam logic [5:0] OP_BGE  = 6'd6;
  localparam logic [5:0] OP_BLTU = 6'd7;
  localparam logic [5:0] OP_BGEU = 6'd8;

  localparam int CW = QUEUE_ADDR_W + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM, S_FLUSH} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } entry_t;

  state_t state_reg, state_next;

  logic [CW-1:0]           count_reg;
  logic [QUEUE_ADDR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [31:0]             req_pc_reg;
  logic                    req_pred_reg;
  entry_t                  queue_mem [QUEUE_SIZE];

  logic        q_full, q_empty;
  logic        can_issue, can_accept, do_pop;
  logic [2:0]  dec_type;
  logic [5:0]  dec_op;
  logic [31:0] dec_imm;
  logic [31:0] j_imm, b_imm;

  assign q_full  = (count_reg == FULL_COUNT);
  assign q_empty = (count_reg == '0);

  // The single outstanding request always has a free slot, so issuing at SIZE-1 is safe.
  assign can_issue  = rdy_in && (state_reg == S_IDLE) && !stop_fetching && !roll_back && !q_full;
  assign can_accept = rdy_in && (state_reg == S_WAIT_MEM) && bus.icache_valid && !roll_back;
  assign do_pop     = rdy_in && !roll_back && !q_empty && bus.out_ready;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_reg <= S_IDLE;
    else if (rdy_in) state_reg <= state_next;
  end

  // Next-state logic; a roll_back in WAIT_MEM still owes one response, which FLUSH swallows.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (can_issue) state_next = S_WAIT_MEM;
      S_WAIT_MEM: begin
        if (bus.icache_valid) state_next = S_IDLE;
        else if (roll_back)   state_next = S_FLUSH;
      end
      S_FLUSH:    if (bus.icache_valid) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  assign j_imm = {{11{bus.icache_inst[31]}}, bus.icache_inst[31], bus.icache_inst[19:12],
                  bus.icache_inst[20], bus.icache_inst[30:21], 1'b0};
  assign b_imm = {{19{bus.icache_inst[31]}}, bus.icache_inst[31], bus.icache_inst[7],
                  bus.icache_inst[30:25], bus.icache_inst[11:8], 1'b0};

  always_comb begin
    dec_type = TYPE_NONE;
    dec_op   = OP_NONE;
    dec_imm  = '0;
    case (bus.icache_inst[6:0])
      7'b1101111: begin dec_type = TYPE_JAL;  dec_op = OP_JAL;  dec_imm = j_imm; end
      7'b1100111: begin dec_type = TYPE_JALR; dec_op = OP_JALR; end
      7'b1100011: begin
        dec_type = TYPE_B;
        dec_imm  = b_imm;
        case (bus.icache_inst[14:12])
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          3'b110:  dec_op = OP_BLTU;
          3'b111:  dec_op = OP_BGEU;
          default: dec_op = OP_NONE;
        endcase
      end
      default: ;
    endcase
  end

  // Output logic; predecode is only driven during the accept pulse so the BTB sees zeros otherwise.
  always_comb begin
    bus.icache_req        = can_issue && !rst_in;
    bus.icache_addr       = pc_in;
    fetch_new_instruction = can_accept && !rst_in;
    op_type               = fetch_new_instruction ? dec_type : TYPE_NONE;
    op_in                 = fetch_new_instruction ? dec_op   : OP_NONE;
    imm                   = fetch_new_instruction ? dec_imm  : 32'd0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      req_pc_reg   <= '0;
      req_pred_reg <= 1'b0;
    end else if (can_issue) begin
      req_pc_reg   <= pc_in;
      req_pred_reg <= predict_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else if (rdy_in) begin
      if (roll_back) begin
        count_reg  <= '0;
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
      end else begin
        if (can_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (do_pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({can_accept, do_pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (can_accept) queue_mem[wr_ptr_reg] <= '{inst: bus.icache_inst, pc: req_pc_reg, pred: req_pred_reg};
  end

  assign bus.out_valid   = !q_empty;
  assign bus.queue_full  = q_full;
  assign bus.out_inst    = queue_mem[rd_ptr_reg].inst;
  assign bus.out_pc      = queue_mem[rd_ptr_reg].pc;
  assign bus.out_predict = queue_mem[rd_ptr_reg].pred;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
    end else begin
      if (fetch_new_instruction) stat_fetched <= stat_fetched + 32'd1;
      if (rdy_in && (state_reg == S_IDLE) && (q_full || stop_fetching))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
